// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if -- result bundle produced by the UART receiver.
//
// Optional feature: UART_RX_PARITY_EN (when undefined, o_parityErr is held at 0).
//
// Signals (all driven by the receiver, master side):
//   o_rxStrobe   one-cycle pulse when a frame completes
//   o_rxByte     last received data word (NUM_DATA_BITS wide, LSB first on the line)
//   o_frameErr   last frame had a stop bit sampled low
//   o_parityErr  last frame failed the parity check
//   o_break      last frame was a break condition
//   o_busy       receiver is not idle
//
// Modports: master = receiver side, slave = consumer side.

interface uart_rx_ext_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     o_rxStrobe;
  logic [NUM_DATA_BITS-1:0] o_rxByte;
  logic                     o_frameErr;
  logic                     o_parityErr;
  logic                     o_break;
  logic                     o_busy;

  modport master (
    output o_rxStrobe, o_rxByte, o_frameErr, o_parityErr, o_break, o_busy
  );

  modport slave (
    input  o_rxStrobe, o_rxByte, o_frameErr, o_parityErr, o_break, o_busy
  );
endinterface

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with frame-error and break detection.
//
// Optional feature: define UART_RX_PARITY_EN to add one parity bit after the
// data bits (checked against PARITY_ODD). Without it the frame has no parity
// bit and o_parityErr stays 0.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_rx       asynchronous serial line, idle high
//   rxIf       uart_rx_ext_if.master: strobe, data word, error flags, busy
//
// States:
//   IDLE      | waiting for a falling edge on the synchronized line
//   START     | timing to the middle of the start bit, rejecting glitches
//   DATA      | sampling NUM_DATA_BITS data bits, LSB first
//   PARITY    | sampling the parity bit (UART_RX_PARITY_EN only)
//   STOP      | sampling NUM_STOP_BITS stop bits
//   WAIT_HIGH | after a framing error, waiting for the line to return high

module uart_rx_ext #(
  parameter int CLKS_PER_BIT  = 217,
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_STOP_BITS = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_rx,
  uart_rx_ext_if.master rxIf
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [TW-1:0] HALF_CNT = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(NUM_DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(NUM_STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
`ifdef UART_RX_PARITY_EN
    , PARITY  = 3'd3
`endif
  } state_t;

  state_t state, stateNext;

  logic rxMeta, rxS;

  logic [TW-1:0]            timer, timerNext;
  logic [IW-1:0]            bitIdx, bitIdxNext;
  logic [NUM_DATA_BITS-1:0] shadow, shadowNext;
  logic                     stopErr, stopErrNext;
  logic                     loadOut;
  logic                     frameErrNow, breakNow, parityErrNow;

  logic                     strobeQ, frameErrQ, parityErrQ, breakQ;
  logic [NUM_DATA_BITS-1:0] rxByteQ;

`ifdef UART_RX_PARITY_EN
  logic parBit, parBitNext;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= i_rx;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      bitIdx  <= '0;
      shadow  <= '0;
      stopErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit  <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      timer   <= timerNext;
      bitIdx  <= bitIdxNext;
      shadow  <= shadowNext;
      stopErr <= stopErrNext;
`ifdef UART_RX_PARITY_EN
      parBit  <= parBitNext;
`endif
    end
  end

  always_comb begin
    stateNext   = state;
    timerNext   = timer + TW'(1);
    bitIdxNext  = bitIdx;
    shadowNext  = shadow;
    stopErrNext = stopErr;
    loadOut     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parBitNext  = parBit;
`endif

    case (state)
      IDLE: begin
        timerNext   = '0;
        bitIdxNext  = '0;
        stopErrNext = 1'b0;
        if (!rxS) stateNext = START;
      end

      START: begin
        if (timer == HALF_CNT) begin
          timerNext = '0;
          // A high line at mid start bit is a glitch: drop it silently.
          stateNext = rxS ? IDLE : DATA;
        end
      end

      DATA: begin
        if (timer == LAST_CNT) begin
          timerNext  = '0;
          shadowNext = {rxS, shadow[NUM_DATA_BITS-1:1]};
          if (bitIdx == LAST_DATA) begin
            bitIdxNext = '0;
`ifdef UART_RX_PARITY_EN
            stateNext  = PARITY;
`else
            stateNext  = STOP;
`endif
          end else begin
            bitIdxNext = bitIdx + IW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer == LAST_CNT) begin
          timerNext  = '0;
          parBitNext = rxS;
          stateNext  = STOP;
        end
      end
`endif

      STOP: begin
        if (timer == LAST_CNT) begin
          timerNext = '0;
          if (!rxS) stopErrNext = 1'b1;
          if (bitIdx == LAST_STOP) begin
            bitIdxNext = '0;
            loadOut    = 1'b1;
            // A framing error may mean the line is still low (break);
            // do not re-arm until it has returned high.
            stateNext  = (stopErr || !rxS) ? WAIT_HIGH : IDLE;
          end else begin
            bitIdxNext = bitIdx + IW'(1);
          end
        end
      end

      WAIT_HIGH: begin
        timerNext = '0;
        if (rxS) stateNext = IDLE;
      end

      default: begin
        stateNext  = IDLE;
        timerNext  = '0;
        bitIdxNext = '0;
      end
    endcase
  end

  // Flag values for the frame completing this cycle (used only with loadOut).
  assign frameErrNow = stopErr | ~rxS;
`ifdef UART_RX_PARITY_EN
  assign parityErrNow = (^{parBit, shadow}) ^ PARITY_ODD[0];
  assign breakNow     = frameErrNow & (shadow == '0) & ~parBit;
`else
  assign parityErrNow = 1'b0;
  assign breakNow     = frameErrNow & (shadow == '0);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      strobeQ    <= 1'b0;
      rxByteQ    <= '0;
      frameErrQ  <= 1'b0;
      parityErrQ <= 1'b0;
      breakQ     <= 1'b0;
    end else begin
      strobeQ <= loadOut;
      if (loadOut) begin
        rxByteQ    <= shadow;
        frameErrQ  <= frameErrNow;
        parityErrQ <= parityErrNow;
        breakQ     <= breakNow;
      end
    end
  end

  assign rxIf.o_rxStrobe  = strobeQ;
  assign rxIf.o_rxByte    = rxByteQ;
  assign rxIf.o_frameErr  = frameErrQ;
  assign rxIf.o_parityErr = parityErrQ;
  assign rxIf.o_break     = breakQ;
  assign rxIf.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext -- bench for uart_rx_ext.
// DUT A: 8 data bits, 1 stop bit, 217 clocks per bit.
// DUT B: 8 data bits, 2 stop bits, 16 clocks per bit.
// Expected frames are queued per DUT as {data, frameErr, parityErr, break}
// and compared when each strobe appears.

module tb_uart_rx_ext;

  localparam int CPB_A = 217;
  localparam int CPB_B = 16;

  logic clk = 1'b0;
  logic rstA, rstB;
  logic rxA, rxB;

  int checks = 0;
  int errors = 0;
  int strobeCnt [2];
  logic prevStrobe [2];
  logic [10:0] expQ [2][$];

  uart_rx_ext_if #(.NUM_DATA_BITS(8)) ifA ();
  uart_rx_ext_if #(.NUM_DATA_BITS(8)) ifB ();

  uart_rx_ext #(
    .CLKS_PER_BIT(CPB_A), .NUM_DATA_BITS(8), .NUM_STOP_BITS(1), .PARITY_ODD(0)
  ) dutA (
    .i_clk(clk), .i_reset_n(rstA), .i_rx(rxA), .rxIf(ifA)
  );

  uart_rx_ext #(
    .CLKS_PER_BIT(CPB_B), .NUM_DATA_BITS(8), .NUM_STOP_BITS(2), .PARITY_ODD(0)
  ) dutB (
    .i_clk(clk), .i_reset_n(rstB), .i_rx(rxB), .rxIf(ifB)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Even parity is the only setting exercised (PARITY_ODD=0).
  function automatic logic expPar(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard monitors.
  always @(negedge clk) begin
    logic [10:0] got, exp;
    got = {ifA.o_rxByte, ifA.o_frameErr, ifA.o_parityErr, ifA.o_break};
    if (ifA.o_rxStrobe) begin
      strobeCnt[0]++;
      checks++;
      if (prevStrobe[0]) begin
        errors++;
        $display("FAIL strobe_width_A: strobe high for 2+ cycles, required 1");
      end else if (expQ[0].size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe_A: got %h, required no strobe", got);
      end else begin
        exp = expQ[0].pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL frame_A: got byte %h fe %b pe %b brk %b, required byte %h fe %b pe %b brk %b",
                   got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
      end
    end
    prevStrobe[0] = ifA.o_rxStrobe;
  end

  always @(negedge clk) begin
    logic [10:0] got, exp;
    got = {ifB.o_rxByte, ifB.o_frameErr, ifB.o_parityErr, ifB.o_break};
    if (ifB.o_rxStrobe) begin
      strobeCnt[1]++;
      checks++;
      if (prevStrobe[1]) begin
        errors++;
        $display("FAIL strobe_width_B: strobe high for 2+ cycles, required 1");
      end else if (expQ[1].size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe_B: got %h, required no strobe", got);
      end else begin
        exp = expQ[1].pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL frame_B: got byte %h fe %b pe %b brk %b, required byte %h fe %b pe %b brk %b",
                   got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
      end
    end
    prevStrobe[1] = ifB.o_rxStrobe;
  end

  task automatic driveBits(input int sel, input logic v, input int nBits);
    int cpb;
    cpb = (sel == 0) ? CPB_A : CPB_B;
    @(negedge clk);
    if (sel == 0) rxA = v;
    else          rxB = v;
    repeat (nBits * cpb - 1) @(negedge clk);
  endtask

  task automatic sendFrame(input int sel, input logic [7:0] data, input logic par,
                           input logic stop1, input logic stop2);
    driveBits(sel, 1'b0, 1);
    for (int i = 0; i < 8; i++) driveBits(sel, data[i], 1);
`ifdef UART_RX_PARITY_EN
    driveBits(sel, par, 1);
`endif
    driveBits(sel, stop1, 1);
    if (sel == 1) driveBits(sel, stop2, 1);
  endtask

  task automatic pushExp(input int sel, input logic [7:0] d, input logic fe,
                         input logic pe, input logic brk);
    expQ[sel].push_back({d, fe, pe, brk});
  endtask

  task automatic test_reset();
    rxA = 1'b1; rxB = 1'b1; rstA = 1'b0; rstB = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({ifA.o_rxStrobe, ifA.o_rxByte, ifA.o_frameErr, ifA.o_parityErr, ifA.o_break, ifA.o_busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs_A: got %b, required 0",
               {ifA.o_rxStrobe, ifA.o_rxByte, ifA.o_frameErr, ifA.o_parityErr, ifA.o_break, ifA.o_busy});
    end
    checks++;
    if ({ifB.o_rxStrobe, ifB.o_rxByte, ifB.o_frameErr, ifB.o_parityErr, ifB.o_break, ifB.o_busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs_B: got %b, required 0",
               {ifB.o_rxStrobe, ifB.o_rxByte, ifB.o_frameErr, ifB.o_parityErr, ifB.o_break, ifB.o_busy});
    end
    rstA = 1'b1; rstB = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (ifA.o_busy !== 1'b0 || ifB.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busyA %b busyB %b, required 0 0", ifA.o_busy, ifB.o_busy);
    end
  endtask

  task automatic test_basic();
    int s0;
    s0 = strobeCnt[0];
    pushExp(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    sendFrame(0, 8'hA5, ^8'hA5, 1'b1, 1'b1);
    repeat (CPB_A) @(negedge clk);
    checks++;
    if (expQ[0].size() != 0 || strobeCnt[0] != s0 + 1) begin
      errors++;
      $display("FAIL basic_strobe: got %0d strobes (%0d pending), required 1", strobeCnt[0] - s0, expQ[0].size());
      expQ[0].delete();
    end
    checks++;
    if (ifA.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 0", ifA.o_busy);
    end
  endtask

  task automatic test_glitch();
    int s0;
    s0 = strobeCnt[0];
    @(negedge clk) rxA = 1'b0;
    repeat (50) @(negedge clk);
    rxA = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 || ifA.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got %0d strobes busy %b, required 0 strobes busy 0",
               strobeCnt[0] - s0, ifA.o_busy);
    end
    pushExp(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    sendFrame(0, 8'h3C, ^8'h3C, 1'b1, 1'b1);
    repeat (CPB_A) @(negedge clk);
    checks++;
    if (expQ[0].size() != 0 || strobeCnt[0] != s0 + 1) begin
      errors++;
      $display("FAIL glitch_next_frame: got %0d strobes, required 1", strobeCnt[0] - s0);
      expQ[0].delete();
    end
  endtask

  task automatic test_frame_err();
    int s0;
    s0 = strobeCnt[0];
    pushExp(0, 8'h81, 1'b1, expPar(8'h81, ^8'h81), 1'b0);
    sendFrame(0, 8'h81, ^8'h81, 1'b0, 1'b0);
    repeat (3 * CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 1) begin
      errors++;
      $display("FAIL frame_err_low_hold: got %0d strobes, required 1", strobeCnt[0] - s0);
    end
    checks++;
    if (ifA.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_wait_high: got busy %b, required 1", ifA.o_busy);
    end
    @(negedge clk) rxA = 1'b1;
    repeat (2 * CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 1 || ifA.o_busy !== 1'b0 || expQ[0].size() != 0) begin
      errors++;
      $display("FAIL frame_err_release: got %0d strobes busy %b, required 1 strobe busy 0",
               strobeCnt[0] - s0, ifA.o_busy);
      expQ[0].delete();
    end
  endtask

  task automatic test_break();
    int s0;
    s0 = strobeCnt[0];
    pushExp(0, 8'h00, 1'b1, expPar(8'h00, 1'b0), 1'b1);
    @(negedge clk) rxA = 1'b0;
    repeat (12 * CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 1) begin
      errors++;
      $display("FAIL break_strobes: got %0d strobes, required 1", strobeCnt[0] - s0);
    end
    rxA = 1'b1;
    repeat (2 * CPB_A) @(negedge clk);
    pushExp(0, 8'h55, 1'b0, 1'b0, 1'b0);
    sendFrame(0, 8'h55, ^8'h55, 1'b1, 1'b1);
    repeat (CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 2 || expQ[0].size() != 0) begin
      errors++;
      $display("FAIL break_then_frame: got %0d strobes, required 2", strobeCnt[0] - s0);
      expQ[0].delete();
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [7:0] vals [3];
    vals[0] = 8'h12; vals[1] = 8'hED; vals[2] = 8'h00;
    s0 = strobeCnt[0];
    for (int i = 0; i < 3; i++) begin
      pushExp(0, vals[i], 1'b0, 1'b0, 1'b0);
      sendFrame(0, vals[i], ^vals[i], 1'b1, 1'b1);
    end
    repeat (CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 3 || expQ[0].size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got %0d strobes, required 3", strobeCnt[0] - s0);
      expQ[0].delete();
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int s0;
    s0 = strobeCnt[0];
    pushExp(0, 8'h01, 1'b0, 1'b1, 1'b0);
    sendFrame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    pushExp(0, 8'h01, 1'b0, 1'b0, 1'b0);
    sendFrame(0, 8'h01, 1'b1, 1'b1, 1'b1);
    repeat (CPB_A) @(negedge clk);
    checks++;
    if (strobeCnt[0] != s0 + 2 || expQ[0].size() != 0) begin
      errors++;
      $display("FAIL parity_frames: got %0d strobes, required 2", strobeCnt[0] - s0);
      expQ[0].delete();
    end
  endtask
`endif

  task automatic test_two_stop();
    int s0;
    s0 = strobeCnt[1];
    pushExp(1, 8'h3A, 1'b0, 1'b0, 1'b0);
    sendFrame(1, 8'h3A, ^8'h3A, 1'b1, 1'b1);
    pushExp(1, 8'hF0, 1'b1, expPar(8'hF0, ^8'hF0), 1'b0);
    sendFrame(1, 8'hF0, ^8'hF0, 1'b1, 1'b0);
    @(negedge clk) rxB = 1'b1;
    repeat (3 * CPB_B) @(negedge clk);
    checks++;
    if (strobeCnt[1] != s0 + 2 || expQ[1].size() != 0) begin
      errors++;
      $display("FAIL two_stop_frames: got %0d strobes, required 2", strobeCnt[1] - s0);
      expQ[1].delete();
    end
    checks++;
    if (ifB.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL two_stop_busy: got %b, required 0", ifB.o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    s0 = strobeCnt[1];
    driveBits(1, 1'b0, 1);
    driveBits(1, 1'b1, 3);
    checks++;
    if (ifB.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy: got %b, required 1", ifB.o_busy);
    end
    @(negedge clk) rstB = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifB.o_rxStrobe, ifB.o_rxByte, ifB.o_frameErr, ifB.o_parityErr, ifB.o_break, ifB.o_busy} !== 13'b0) begin
      errors++;
      $display("FAIL mid_frame_reset_outputs: got %b, required 0",
               {ifB.o_rxStrobe, ifB.o_rxByte, ifB.o_frameErr, ifB.o_parityErr, ifB.o_break, ifB.o_busy});
    end
    rstB = 1'b1;
    repeat (14 * CPB_B) @(negedge clk);
    checks++;
    if (strobeCnt[1] != s0 || ifB.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_discard: got %0d strobes busy %b, required 0 strobes busy 0",
               strobeCnt[1] - s0, ifB.o_busy);
    end
    pushExp(1, 8'h42, 1'b0, 1'b0, 1'b0);
    sendFrame(1, 8'h42, ^8'h42, 1'b1, 1'b1);
    repeat (2 * CPB_B) @(negedge clk);
    checks++;
    if (strobeCnt[1] != s0 + 1 || expQ[1].size() != 0) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d strobes, required 1", strobeCnt[1] - s0);
      expQ[1].delete();
    end
  endtask

  initial begin
    strobeCnt[0] = 0; strobeCnt[1] = 0;
    prevStrobe[0] = 1'b0; prevStrobe[1] = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_break();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_two_stop();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217: clocks per serial bit, legal range 4..65535.
REQ-002 Parameter NUM_DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-003 Parameter NUM_STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity and 1 selects odd; it is used only when UART_RX_PARITY_EN is defined.
REQ-005 Port i_clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 Port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 Port o_rxStrobe, output, 1 bit: one-cycle pulse when a frame completes.
REQ-009 Port o_rxByte, output, NUM_DATA_BITS bits: last received data word, LSB first on the line.
REQ-010 Port o_frameErr, output, 1 bit: last frame had a stop bit sampled low.
REQ-011 Port o_parityErr, output, 1 bit: last frame failed the parity check.
REQ-012 Port o_break, output, 1 bit: last frame was a break condition.
REQ-013 Port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer; both flops reset to 1, and all logic SHALL use only the synchronized value rx_s.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH; the bit-timer width SHALL be $clog2(CLKS_PER_BIT).
REQ-016 In IDLE, rx_s==0 SHALL move the FSM to START and clear the bit timer.
REQ-017 In START, rx_s SHALL be sampled at timer==(CLKS_PER_BIT-1)/2; a sample of 0 moves to DATA, and a sample of 1 is a glitch that returns to IDLE with no strobe and no flag change.
REQ-018 In DATA, PARITY and STOP, each bit SHALL be sampled when the timer reaches CLKS_PER_BIT-1 measured from the previous sample point; the timer SHALL then wrap to 0.
REQ-019 DATA SHALL shift NUM_DATA_BITS samples LSB first into a shadow register, then go to PARITY (macro defined) or to STOP.
REQ-020 STOP SHALL sample NUM_STOP_BITS bits; any stop sample of 0 SHALL set the frame-error condition.
REQ-021 On the cycle after the final stop sample, o_rxStrobe SHALL be 1 for exactly one cycle.
REQ-022 In that same cycle, o_rxByte, o_frameErr, o_parityErr and o_break SHALL load the new frame's values and SHALL hold them until the next strobe.
REQ-023 A frame error with shadow data all zero (and a parity sample of 0 if enabled) SHALL set o_break=1 together with o_frameErr=1.
REQ-024 After a strobe with o_frameErr=1, the FSM SHALL go to WAIT_HIGH and stay there until rx_s==1, then go to IDLE; an error-free strobe SHALL go directly to IDLE.
REQ-025 A continuous low line SHALL therefore produce exactly one strobe.
REQ-026 Back-to-back frames with no idle gap SHALL be received without loss.
REQ-027 Latency SHALL be 2 synchronizer cycles plus the frame duration up to the mid-point of the last stop bit, plus 1 cycle.
REQ-028 Reaching any unused state encoding SHALL force the FSM to IDLE on the next clock.

Reset
REQ-029 While i_reset_n==0, all outputs SHALL be 0, the FSM SHALL be IDLE, the timer and bit index SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no strobe; after release, the FSM SHALL wait for a fresh falling edge.

Configuration
REQ-031 With UART_RX_PARITY_EN defined, one parity bit SHALL follow the data bits, be checked against PARITY_ODD, and drive o_parityErr.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, o_parityErr SHALL be tied to 0, and the frame SHALL contain no parity bit.

Verification
REQ-033 8N1, CLKS_PER_BIT=217, send 0xA5 -> one strobe, o_rxByte=0xA5, all flags 0, o_busy low after the strobe.
REQ-034 Drive i_rx low for 50 clocks, then high -> no strobe, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-035 Send 0x81 with its stop bit low -> strobe with o_frameErr=1, o_break=0, o_rxByte=0x81; no second strobe until the line returns high.
REQ-036 Hold i_rx low for 12 bit times, then high, then send 0x55 -> one strobe with o_break=1 and o_frameErr=1, then one strobe with 0x55 and flags 0.
REQ-037 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x01 with parity bit 0 -> o_parityErr=1; 0x01 with parity bit 1 -> o_parityErr=0.
REQ-038 NUM_STOP_BITS=2, send 0xF0 with the second stop bit low -> o_frameErr=1; pulse i_reset_n low mid-frame -> all outputs 0, no strobe, next 0x42 frame received correctly.
